// File: rtl/jtag_arb_pkg.sv
// Shared types and header layout for the JTAG transmit-FIFO arbiter.
package jtag_arb_pkg;

  localparam int MAX_REQ     = 4;
  localparam int HDR_ID_MSB  = 7;
  localparam int HDR_ID_LSB  = 6;
  localparam int HDR_RSV_MSB = 5;
  localparam int HDR_RSV_LSB = 4;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} arb_state_e;

  function automatic logic [7:0] make_header(input logic [1:0] id, input logic [3:0] len);
    logic [7:0] h;
    h = '0;
    h[HDR_ID_MSB:HDR_ID_LSB]   = id;
    h[HDR_RSV_MSB:HDR_RSV_LSB] = 2'b00;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return h;
  endfunction

endpackage

// File: rtl/jtag_tx_arbiter_rr_pick.sv
// Combinational winner selector: round-robin after last_id, or lowest index
// first when JTAG_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import jtag_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_id,
  output logic [1:0]         win,
  output logic               any
);

  logic [1:0] idx;

  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
`ifdef JTAG_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = 2'(i);
      if (req[idx]) win = idx;
    end
`else
    // Walk offsets from farthest to nearest so the entry just after last_id wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = 2'((int'(last_id) + i) % NUM_REQ);
      if (req[idx]) win = idx;
    end
`endif
  end

endmodule

// File: rtl/jtag_tx_arbiter.sv
// Shares the JTAG transmit FIFO push port between producers, one framed packet
// per grant. Define JTAG_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module jtag_tx_arbiter
  import jtag_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) (
  input  logic                 tck,
  input  logic                 aclr_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] req_len,
  input  logic [NUM_REQ-1:0]   src_valid,
  input  logic [NUM_REQ*8-1:0] src_data,
  output logic [NUM_REQ-1:0]   src_ready,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 push_fifo,
  output logic [7:0]           Data_out,
  input  logic                 full_fifo
);

  arb_state_e       state, state_nxt;
  logic [1:0]       id, last_id, win;
  logic [LEN_W-1:0] len, remaining, remaining_nxt;
  logic             any, load;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .last_id (last_id),
    .win     (win),
    .any     (any)
  );

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    load          = 1'b0;
    push_fifo     = 1'b0;
    Data_out      = 8'h00;
    src_ready     = '0;
    case (state)
      IDLE: begin
        if (any) begin
          load      = 1'b1;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        push_fifo = !full_fifo;
        Data_out  = make_header(id, len);
        if (!full_fifo) begin
          remaining_nxt = len;
          state_nxt     = (len == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        src_ready[id] = !full_fifo;
        push_fifo     = src_valid[id] & !full_fifo;
        Data_out      = src_data[{id, 3'b000} +: 8];
        if (push_fifo) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tck or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (load)                   gnt <= NUM_REQ'(1) << win;
      else if (state_nxt == IDLE) gnt <= '0;
    end
  end

`ifdef JTAG_ARB_FIXED_PRIO_EN
  assign last_id = '0;
`else
  always_ff @(posedge tck or negedge aclr_n) begin
    if (!aclr_n)                       last_id <= 2'(NUM_REQ - 1);
    else if (state == HEADER && !full_fifo) last_id <= id;
  end
`endif

  // Packet descriptor and byte counter carry no reset; state gates their use.
  always_ff @(posedge tck) begin
    if (load) begin
      id  <= win;
      len <= req_len[{win, 2'b00} +: LEN_W];
    end
    remaining <= remaining_nxt;
  end

endmodule

// File: tb/tb_jtag_tx_arbiter.sv
// Directed bench for jtag_tx_arbiter: framing, round-robin order, stalls,
// request drop, mid-packet reset and src_valid gaps.
module tb_jtag_tx_arbiter;

  logic        tck = 1'b0;
  logic        aclr_n;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_ready;
  logic [3:0]  gnt;
  logic        busy;
  logic        push_fifo;
  logic [7:0]  Data_out;
  logic        full_fifo;

  int n_chk  = 0;
  int n_fail = 0;

  jtag_tx_arbiter #(.NUM_REQ(4), .LEN_W(4)) dut (
    .tck       (tck),
    .aclr_n    (aclr_n),
    .req       (req),
    .req_len   (req_len),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .gnt       (gnt),
    .busy      (busy),
    .push_fifo (push_fifo),
    .Data_out  (Data_out),
    .full_fifo (full_fifo)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(posedge tck);
    #1;
  endtask

  task automatic smp();
    @(negedge tck);
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 20; i++) begin
      smp();
      if (!busy) break;
      nxt();
    end
    chk("idle_wait_busy", {31'd0, busy}, 32'd0);
    nxt();
  endtask

  task automatic do_reset();
    aclr_n = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    aclr_n = 1'b1;
  endtask

  logic [7:0] exp_b;

  initial begin
    aclr_n    = 1'b0;
    req       = '0;
    req_len   = '0;
    src_valid = '0;
    src_data  = '0;
    full_fifo = 1'b0;

    // Reset state
    #2;
    chk("rst_gnt",   {28'd0, gnt}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_push",  {31'd0, push_fifo}, 32'd0);
    chk("rst_dout",  {24'd0, Data_out}, 32'h00);
    chk("rst_ready", {28'd0, src_ready}, 32'd0);
    do_reset();

    // Test 1: requester 0, three payload bytes
    req = 4'b0001; req_len[3:0] = 4'd3; src_valid = 4'b1111; src_data[7:0] = 8'hA1;
    smp();
    chk("t1_idle_push", {31'd0, push_fifo}, 32'd0);
    nxt(); req = 4'b0000;
    smp();
    chk("t1_hdr_gnt",  {28'd0, gnt}, 32'b0001);
    chk("t1_hdr_busy", {31'd0, busy}, 32'd1);
    chk("t1_hdr_push", {31'd0, push_fifo}, 32'd1);
    chk("t1_hdr_dout", {24'd0, Data_out}, 32'h03);
    for (int k = 0; k < 3; k++) begin
      nxt(); src_data[7:0] = 8'hA1 + 8'(k);
      smp();
      exp_b = 8'hA1 + 8'(k);
      chk("t1_pl_push",  {31'd0, push_fifo}, 32'd1);
      chk("t1_pl_dout",  {24'd0, Data_out}, {24'd0, exp_b});
      chk("t1_pl_ready", {28'd0, src_ready}, 32'b0001);
    end
    nxt();
    smp();
    chk("t1_end_busy", {31'd0, busy}, 32'd0);
    chk("t1_end_gnt",  {28'd0, gnt}, 32'd0);
    chk("t1_end_dout", {24'd0, Data_out}, 32'h00);
    nxt(); src_valid = '0;

    // Test 2: all four requesting zero-length packets
    do_reset();
    req = 4'b1111; req_len = '0;
    for (int c = 0; c < 10; c++) begin
      smp();
      chk("t2_push", {31'd0, push_fifo}, {31'd0, c[0]});
      if (c[0]) begin
`ifdef JTAG_ARB_FIXED_PRIO_EN
        exp_b = 8'h00;
`else
        exp_b = {2'((c / 2) % 4), 6'b000000};
`endif
        chk("t2_hdr", {24'd0, Data_out}, {24'd0, exp_b});
      end
      nxt();
    end
    req = '0;
    idle_wait();

    // Test 3: requester 2 stalled by full FIFO after the header
    req = 4'b0100; req_len[11:8] = 4'd2; src_valid = 4'b1111; src_data[23:16] = 8'hC1;
    smp();
    nxt(); req = '0;
    smp();
    chk("t3_hdr_gnt",  {28'd0, gnt}, 32'b0100);
    chk("t3_hdr_dout", {24'd0, Data_out}, 32'h82);
    nxt(); full_fifo = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t3_stall_push",  {31'd0, push_fifo}, 32'd0);
      chk("t3_stall_ready", {28'd0, src_ready}, 32'd0);
      chk("t3_stall_busy",  {31'd0, busy}, 32'd1);
      nxt();
    end
    full_fifo = 1'b0;
    smp();
    chk("t3_b0_push",  {31'd0, push_fifo}, 32'd1);
    chk("t3_b0_dout",  {24'd0, Data_out}, 32'hC1);
    chk("t3_b0_ready", {28'd0, src_ready}, 32'b0100);
    nxt(); src_data[23:16] = 8'hC2;
    smp();
    chk("t3_b1_push", {31'd0, push_fifo}, 32'd1);
    chk("t3_b1_dout", {24'd0, Data_out}, 32'hC2);
    nxt();
    smp();
    chk("t3_end_busy", {31'd0, busy}, 32'd0);
    nxt(); src_valid = '0;

    // Test 4: requester 1 drops req after the header, requester 0 waits
    req = 4'b0010; req_len[7:4] = 4'd4; req_len[3:0] = 4'd0; src_valid = 4'b0010; src_data[15:8] = 8'hD0;
    smp();
    nxt(); req = 4'b0001;
    smp();
    chk("t4_hdr_gnt",  {28'd0, gnt}, 32'b0010);
    chk("t4_hdr_dout", {24'd0, Data_out}, 32'h44);
    for (int k = 0; k < 4; k++) begin
      nxt(); src_data[15:8] = 8'hD0 + 8'(k);
      smp();
      exp_b = 8'hD0 + 8'(k);
      chk("t4_pl_push", {31'd0, push_fifo}, 32'd1);
      chk("t4_pl_dout", {24'd0, Data_out}, {24'd0, exp_b});
      chk("t4_pl_gnt",  {28'd0, gnt}, 32'b0010);
    end
    nxt();
    smp();
    chk("t4_gap_busy", {31'd0, busy}, 32'd0);
    chk("t4_gap_gnt",  {28'd0, gnt}, 32'd0);
    chk("t4_gap_push", {31'd0, push_fifo}, 32'd0);
    nxt();
    smp();
    chk("t4_next_gnt",  {28'd0, gnt}, 32'b0001);
    chk("t4_next_dout", {24'd0, Data_out}, 32'h00);
    nxt(); req = '0; src_valid = '0;
    idle_wait();

    // Test 5: asynchronous reset in the middle of a payload
    req = 4'b0100; req_len[11:8] = 4'd3; src_valid = 4'b0100; src_data[23:16] = 8'h55;
    smp();
    nxt(); req = '0;
    smp();
    nxt();
    smp();
    chk("t5_pl_push", {31'd0, push_fifo}, 32'd1);
    nxt(); aclr_n = 1'b0;
    #1;
    chk("t5_rst_gnt",  {28'd0, gnt}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_push", {31'd0, push_fifo}, 32'd0);
    nxt(); aclr_n = 1'b1; req = 4'b1111; req_len = '0; src_valid = '0;
    smp();
    chk("t5_idle_push", {31'd0, push_fifo}, 32'd0);
    nxt();
    smp();
    chk("t5_first_gnt",  {28'd0, gnt}, 32'b0001);
    chk("t5_first_dout", {24'd0, Data_out}, 32'h00);
    nxt(); req = '0;
    idle_wait();

    // Test 6: src_valid gaps during a two-byte payload
    req = 4'b1000; req_len[15:12] = 4'd2; src_valid = 4'b0000; src_data[31:24] = 8'hE1;
    smp();
    nxt(); req = '0;
    smp();
    chk("t6_hdr_dout", {24'd0, Data_out}, 32'hC2);
    nxt(); src_valid = 4'b1000;
    smp();
    chk("t6_v1_push", {31'd0, push_fifo}, 32'd1);
    chk("t6_v1_dout", {24'd0, Data_out}, 32'hE1);
    nxt(); src_valid = 4'b0000;
    smp();
    chk("t6_v0_push",  {31'd0, push_fifo}, 32'd0);
    chk("t6_v0_ready", {28'd0, src_ready}, 32'b1000);
    chk("t6_v0_busy",  {31'd0, busy}, 32'd1);
    nxt(); src_valid = 4'b1000; src_data[31:24] = 8'hE2;
    smp();
    chk("t6_v2_push", {31'd0, push_fifo}, 32'd1);
    chk("t6_v2_dout", {24'd0, Data_out}, 32'hE2);
    nxt(); src_valid = 4'b0000;
    smp();
    chk("t6_end_push", {31'd0, push_fifo}, 32'd0);
    chk("t6_end_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
